// File: rtl/video_timing_pkg.sv
// Shared types and mode constants for the video timing sequencer.
// Mode indices, polarity/interlace masks and the sequencer state encoding.
package video_timing_pkg;

    typedef logic [3:0] mode_t;

    localparam int    NUM_MODES     = 12;

    localparam mode_t MODE_1080P60  = 4'd0;
    localparam mode_t MODE_720P60   = 4'd1;
    localparam mode_t MODE_1080I60  = 4'd2;
    localparam mode_t MODE_480I60   = 4'd3;
    localparam mode_t MODE_480P60   = 4'd4;
    localparam mode_t MODE_1080I50  = 4'd5;
    localparam mode_t MODE_576P50   = 4'd6;
    localparam mode_t MODE_1080P50  = 4'd7;
    localparam mode_t MODE_720P50   = 4'd8;
    localparam mode_t MODE_1080P30  = 4'd9;
    localparam mode_t MODE_1080P24  = 4'd10;
    localparam mode_t MODE_768P60   = 4'd11;

    localparam logic [15:0] NEG_MASK   = 16'h0848;
    localparam logic [15:0] ILACE_MASK = 16'h002C;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        LOCK,
        RUN,
        DRAIN
    } state_t;

endpackage

// File: rtl/video_timing_sequencer_if.sv
// Host configuration handshake: requested mode index with valid/ready.
// The host drives through master, the sequencer responds through slave.
interface video_timing_sequencer_if;
    import video_timing_pkg::*;

    mode_t cfg_mode;
    logic  cfg_valid;
    logic  cfg_ready;

    modport master (
        output cfg_mode,
        output cfg_valid,
        input  cfg_ready
    );

    modport slave (
        input  cfg_mode,
        input  cfg_valid,
        output cfg_ready
    );

endinterface

// File: rtl/vts_frame_detect.sv
// Frame-start detector: normalises vsync polarity per mode and flags
// the leading edge, restricted to the odd field for interlaced modes.
module vts_frame_detect #(
    parameter logic [15:0] NEG_MASK   = 16'h0848,
    parameter logic [15:0] ILACE_MASK = 16'h002C
) (
    input  logic       pclk,
    input  logic       rst_n,
    input  logic [3:0] mode_sel,
    input  logic       gen_vsync,
    input  logic       gen_field,
    output logic       fs
);

    logic vs_act;
    logic vs_prev;
    logic odd_ok;

    assign vs_act = gen_vsync ^ NEG_MASK[mode_sel];
    assign odd_ok = ~(ILACE_MASK[mode_sel] & gen_field);
    assign fs     = vs_act & ~vs_prev & odd_ok;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            vs_prev <= 1'b0;
        end else begin
            vs_prev <= vs_act;
        end
    end

endmodule

// File: rtl/video_timing_sequencer.sv
// Run-time controller for the sync generator bank: applies host mode and
// run/stop requests only at frame boundaries (drain, settle, lock).
module video_timing_sequencer #(
    parameter logic [3:0]       DEFAULT_MODE = 4'd0,
    parameter int               NUM_MODES    = video_timing_pkg::NUM_MODES,
    parameter logic [15:0]      NEG_MASK     = video_timing_pkg::NEG_MASK,
    parameter logic [15:0]      ILACE_MASK   = video_timing_pkg::ILACE_MASK,
    parameter int               SETTLE_CYC   = 64,
    parameter int               TMO_W        = 23,
    parameter logic [TMO_W-1:0] TMO_CYC      = TMO_W'(5_000_000)
) (
    input  logic                     pclk,
    input  logic                     rst_n,
    video_timing_sequencer_if.slave  cfg,
    input  logic                     run_req,
    input  logic                     pause_req,
    input  logic                     gen_vsync,
    input  logic                     gen_de,
    input  logic                     gen_field,
    output logic                     gen_enable,
    output logic                     gen_pause,
    output logic [3:0]               mode_sel,
    output logic                     locked,
    output logic                     busy,
    output logic                     err_timeout,
    output logic                     err_mode
);

    import video_timing_pkg::*;

    localparam logic [TMO_W-1:0] SETTLE_LAST = TMO_W'(SETTLE_CYC - 1);
    localparam logic [TMO_W-1:0] TMO_LAST    = TMO_CYC - TMO_W'(1);

    state_t           state;
    logic [3:0]       pending;
    logic             chg_pend;
    logic [TMO_W-1:0] cnt;
    logic             fs;
    logic             rdy;
    logic             acc;
    logic             acc_ok;

    assign rdy           = (state == IDLE) || (state == RUN && !chg_pend);
    assign cfg.cfg_ready = rdy;
    assign acc           = cfg.cfg_valid && rdy;
    assign acc_ok        = acc && (int'(cfg.cfg_mode) < NUM_MODES);

    vts_frame_detect #(
        .NEG_MASK   (NEG_MASK),
        .ILACE_MASK (ILACE_MASK)
    ) u_fd (
        .pclk      (pclk),
        .rst_n     (rst_n),
        .mode_sel  (mode_sel),
        .gen_vsync (gen_vsync),
        .gen_field (gen_field),
        .fs        (fs)
    );

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            mode_sel    <= DEFAULT_MODE;
            pending     <= DEFAULT_MODE;
            chg_pend    <= 1'b0;
            cnt         <= '0;
            gen_enable  <= 1'b0;
            gen_pause   <= 1'b0;
            locked      <= 1'b0;
            busy        <= 1'b0;
            err_timeout <= 1'b0;
            err_mode    <= 1'b0;
        end else begin
            err_mode <= acc && !acc_ok;
            if (acc_ok) begin
                pending     <= cfg.cfg_mode;
                chg_pend    <= 1'b1;
                err_timeout <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    if (run_req) begin
                        // a mode accepted in this same cycle is the one started
                        state    <= SETTLE;
                        busy     <= 1'b1;
                        mode_sel <= acc_ok ? cfg.cfg_mode : pending;
                        chg_pend <= 1'b0;
                        cnt      <= '0;
                    end
                end
                SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        state      <= LOCK;
                        gen_enable <= 1'b1;
                        cnt        <= '0;
                    end else begin
                        cnt <= cnt + TMO_W'(1);
                    end
                end
                LOCK: begin
                    if (!run_req) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        gen_enable <= 1'b0;
                    end else if (fs) begin
                        state  <= RUN;
                        busy   <= 1'b0;
                        locked <= 1'b1;
                    end else if (cnt == TMO_LAST) begin
                        state       <= IDLE;
                        busy        <= 1'b0;
                        gen_enable  <= 1'b0;
                        err_timeout <= 1'b1;
                    end else begin
                        cnt <= cnt + TMO_W'(1);
                    end
                end
                RUN: begin
                    // a frozen generator never reaches fs, so hold off draining
                    if (gen_pause) begin
                        if (!pause_req) gen_pause <= 1'b0;
                    end else if (chg_pend || !run_req) begin
                        state <= DRAIN;
                        busy  <= 1'b1;
                    end else if (pause_req && !gen_de) begin
                        gen_pause <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (fs) begin
                        gen_enable <= 1'b0;
                        locked     <= 1'b0;
                        if (run_req) begin
                            state    <= SETTLE;
                            mode_sel <= pending;
                            chg_pend <= 1'b0;
                            cnt      <= '0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    gen_enable <= 1'b0;
                    gen_pause  <= 1'b0;
                    locked     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_video_timing_sequencer.sv
// Self-checking bench for video_timing_sequencer with a behavioural
// sync generator and event-level expectations.
module tb_video_timing_sequencer;

    localparam logic [15:0] NEG   = 16'h0848;
    localparam logic [15:0] ILACE = 16'h002C;
    localparam int          FRAME = 40;
    localparam int          NMODE = 12;

    logic       pclk;
    logic       rst_n;
    logic       run_req, pause_req;
    logic       gen_vsync, gen_de, gen_field;
    logic       gen_enable, gen_pause, locked, busy;
    logic       err_timeout, err_mode;
    logic [3:0] mode_sel;

    video_timing_sequencer_if cfg_if ();

    video_timing_sequencer #(
        .TMO_CYC (23'd1000)
    ) dut (
        .pclk        (pclk),
        .rst_n       (rst_n),
        .cfg         (cfg_if),
        .run_req     (run_req),
        .pause_req   (pause_req),
        .gen_vsync   (gen_vsync),
        .gen_de      (gen_de),
        .gen_field   (gen_field),
        .gen_enable  (gen_enable),
        .gen_pause   (gen_pause),
        .mode_sel    (mode_sel),
        .locked      (locked),
        .busy        (busy),
        .err_timeout (err_timeout),
        .err_mode    (err_mode)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   fc      = 20;
    logic fld     = 1'b0;
    logic vs_low  = 1'b0;
    logic g_fs    = 1'b0;
    logic g_rise  = 1'b0;
    logic s_fs, s_rise, s_de, s_preq;

    typedef struct {
        logic [3:0] mode;
        logic       exp_err;
        logic       exp_tmo;
    } cfg_vec_t;

    cfg_vec_t tbl[5];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Behavioural generator bank: one frame is FRAME cycles, vsync active
    // for the first 3, field toggles per frame in interlaced modes.
    task automatic gen_step();
        logic il;
        logic va;
        il     = ILACE[mode_sel];
        g_fs   = 1'b0;
        g_rise = 1'b0;
        if (!gen_enable) begin
            fc  = 20;
            fld = 1'b0;
        end else if (!gen_pause) begin
            if (fc == FRAME - 1) begin
                fc     = 0;
                fld    = il ? ~fld : 1'b0;
                g_rise = !vs_low;
                g_fs   = !vs_low && !fld;
            end else begin
                fc++;
            end
        end
        va        = (fc < 3) && !vs_low;
        gen_vsync = va ^ NEG[mode_sel];
        gen_field = fld;
        gen_de    = (fc >= 5) && ((fc % 8) < 6);
    endtask

    task automatic tick();
        s_fs   = g_fs;
        s_rise = g_rise;
        s_de   = gen_de;
        s_preq = pause_req;
        @(posedge pclk);
        #1;
        gen_step();
    endtask

    task automatic expect_settle(input string tag);
        int n;
        n = 0;
        while (!gen_enable && n < 200) begin
            tick();
            n++;
        end
        chk({tag, " settle cycles"}, n, 64);
    endtask

    task automatic expect_lock(input string tag, input logic unq_exp);
        int   n, nq, nu;
        logic last_fs;
        n = 0; nq = 0; nu = 0; last_fs = 1'b0;
        while (!locked && n < 400) begin
            tick();
            n++;
            if (s_fs) nq++;
            else if (s_rise) nu++;
            last_fs = s_fs;
        end
        chk({tag, " locked"}, locked, 1);
        chk({tag, " lock edge is fs"}, last_fs, 1);
        chk({tag, " fs count"}, nq, 1);
        chk({tag, " even skipped"}, nu, unq_exp);
        chk({tag, " busy"}, busy, 0);
    endtask

    task automatic expect_switch(input string tag, input logic [3:0] m);
        int n;
        n = 0;
        while (gen_enable && n < 300) begin
            tick();
            n++;
        end
        chk({tag, " drain ends on fs"}, s_fs, 1);
        chk({tag, " mode_sel"}, mode_sel, m);
        chk({tag, " unlocked"}, locked, 0);
        chk({tag, " busy"}, busy, 1);
        expect_settle(tag);
        expect_lock(tag, ILACE[m]);
    endtask

    task automatic send_cfg(input logic [3:0] m);
        cfg_if.cfg_mode  = m;
        cfg_if.cfg_valid = 1'b1;
        tick();
        cfg_if.cfg_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         n, bad;
        logic [3:0] m, cur, exp_m;
        logic       exp_gp;

        rst_n = 1'b1; run_req = 1'b0; pause_req = 1'b0;
        cfg_if.cfg_valid = 1'b0; cfg_if.cfg_mode = 4'd0;
        gen_vsync = 1'b0; gen_de = 1'b0; gen_field = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge pclk);
        #1;
        chk("rst gen_enable", gen_enable, 0);
        chk("rst gen_pause", gen_pause, 0);
        chk("rst locked", locked, 0);
        chk("rst busy", busy, 0);
        chk("rst err_timeout", err_timeout, 0);
        chk("rst err_mode", err_mode, 0);
        chk("rst mode_sel", mode_sel, 0);
        chk("rst cfg_ready", cfg_if.cfg_ready, 1);
        #2 rst_n = 1'b1;
        gen_step();
        tick(); tick();
        chk("idle stays", busy, 0);

        run_req = 1'b1;
        tick();
        chk("boot settle busy", busy, 1);
        chk("boot settle gen_enable", gen_enable, 0);
        expect_settle("boot");
        expect_lock("boot", 1'b0);
        chk("boot mode_sel", mode_sel, 0);
        cur = 4'd0;

        chk("run cfg_ready", cfg_if.cfg_ready, 1);
        send_cfg(4'd3);
        chk("chg cfg_ready", cfg_if.cfg_ready, 0);
        chk("chg err_mode", err_mode, 0);
        expect_switch("to480i", 4'd3);
        cur = 4'd3;

        send_cfg(4'd13);
        chk("bad err_mode", err_mode, 1);
        chk("bad mode_sel", mode_sel, 3);
        chk("bad cfg_ready", cfg_if.cfg_ready, 1);
        tick();
        chk("bad err_mode pulse", err_mode, 0);
        bad = 0;
        repeat (60) begin
            tick();
            if (!gen_enable || busy || !locked || mode_sel != 4'd3) bad++;
        end
        chk("bad no drain", bad, 0);

        n = 0;
        while (!gen_de && n < 100) begin
            tick();
            n++;
        end
        pause_req = 1'b1;
        n = 0; bad = 0;
        while (!gen_pause && n < 100) begin
            tick();
            n++;
            if (!gen_pause && !s_de) bad++;
        end
        chk("pause asserted", gen_pause, 1);
        chk("pause on blank", s_de, 0);
        chk("pause no early miss", bad, 0);
        chk("pause waited line", n > 1, 1);
        pause_req = 1'b0;
        tick();
        chk("pause release", gen_pause, 0);

        for (int k = 0; k < 6; k++) begin
            exp_gp = 1'b0;
            bad = 0;
            for (int i = 0; i < 60; i++) begin
                if ($urandom_range(0, 3) == 0) pause_req = ~pause_req;
                tick();
                exp_gp = exp_gp ? s_preq : (s_preq && !s_de);
                if (gen_pause !== exp_gp || !locked) bad++;
            end
            chk("rnd pause", bad, 0);
            pause_req = 1'b0;
            tick();
            chk("rnd pause off", gen_pause, 0);
            if (k == 0) m = 4'd12;
            else if (k == 1) m = 4'd11;
            else m = 4'($urandom_range(0, 15));
            send_cfg(m);
            chk("rnd err_mode", err_mode, (int'(m) >= NMODE) ? 1 : 0);
            if (int'(m) < NMODE) begin
                chk("rnd cfg_ready", cfg_if.cfg_ready, 0);
                expect_switch("rnd", m);
                cur = m;
            end else begin
                tick();
                chk("rnd keep mode", mode_sel, cur);
                chk("rnd keep locked", locked, 1);
            end
        end

        run_req = 1'b0;
        tick();
        chk("stop drain", busy, 1);
        n = 0;
        while (gen_enable && n < 200) begin
            tick();
            n++;
        end
        chk("stop on fs", s_fs, 1);
        chk("stop idle", busy, 0);
        chk("stop unlocked", locked, 0);

        vs_low = 1'b1;
        run_req = 1'b1;
        tick();
        expect_settle("tmo");
        n = 0;
        while (!err_timeout && n < 1100) begin
            tick();
            n++;
        end
        chk("tmo cycles", n, 1000);
        chk("tmo gen_enable", gen_enable, 0);
        chk("tmo idle", busy, 0);
        chk("tmo locked", locked, 0);
        run_req = 1'b0;
        vs_low = 1'b0;
        tick();
        chk("tmo sticky", err_timeout, 1);

        tbl[0] = '{4'd14, 1'b1, 1'b1};
        tbl[1] = '{4'd12, 1'b1, 1'b1};
        tbl[2] = '{4'd7,  1'b0, 1'b0};
        tbl[3] = '{4'd15, 1'b1, 1'b0};
        tbl[4] = '{4'd1,  1'b0, 1'b0};
        exp_m = cur;
        for (int i = 0; i < 5; i++) begin
            send_cfg(tbl[i].mode);
            if (int'(tbl[i].mode) < NMODE) exp_m = tbl[i].mode;
            chk("tbl err_mode", err_mode, tbl[i].exp_err);
            chk("tbl err_timeout", err_timeout, tbl[i].exp_tmo);
            chk("tbl cfg_ready", cfg_if.cfg_ready, 1);
            chk("tbl stays idle", busy | gen_enable, 0);
        end
        run_req = 1'b1;
        tick();
        chk("tbl mode_sel", mode_sel, exp_m);
        expect_settle("tbl");
        expect_lock("tbl", ILACE[exp_m]);

        run_req = 1'b0;
        tick();
        chk("rdrain busy", busy, 1);
        chk("rdrain gen_enable", gen_enable, 1);
        #3 rst_n = 1'b0;
        #1;
        chk("arst gen_enable", gen_enable, 0);
        chk("arst locked", locked, 0);
        chk("arst mode_sel", mode_sel, 0);
        chk("arst busy", busy, 0);
        chk("arst cfg_ready", cfg_if.cfg_ready, 1);
        #2 rst_n = 1'b1;
        tick();
        chk("arst idle", busy | gen_enable, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/video_timing_sequencer.md
Name: video_timing_sequencer

Overview:
- Run-time controller for a bank of video sync generator instances, one per timing mode.
- Owns the generator `enable`/`pause` inputs and the `mode_sel` that drives the output mux.
- Accepts mode-change and run/stop requests from the host. Applies them only at frame boundaries: drain, disable, settle, re-enable, confirm lock.
- Sits between the host register block and the timing generator bank in the pclk domain.

Parameters:
- DEFAULT_MODE, 0, mode index used after reset (0=1080P@60).
- NUM_MODES, 12, number of valid mode indices (0..NUM_MODES-1).
- NEG_MASK, 16'h0848, bit i=1: mode i has negated vsync (modes 3=480I@60, 6=P576@50, 11=768P@60).
- ILACE_MASK, 16'h002C, bit i=1: mode i is interlaced (2=1080I@60, 3=480I@60, 5=1080I@50).
- SETTLE_CYC, 64, pclk cycles the generator is held disabled after a mode switch.
- TMO_W, 23, width of the lock-timeout counter.
- TMO_CYC, 23'd5_000_000, pclk cycles allowed in LOCK before a timeout error.

Ports:
- pclk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- cfg_mode  in  4  requested mode index
- cfg_valid  in  1  cfg_mode valid
- cfg_ready  out  1  sequencer accepts cfg_mode
- run_req  in  1  level: 1=video on, 0=stop
- pause_req  in  1  level: host pause request
- gen_vsync  in  1  vsync from the selected generator, raw polarity
- gen_de  in  1  de from the selected generator
- gen_field  in  1  field from the selected generator
- gen_enable  out  1  to generator `enable`
- gen_pause  out  1  to generator `pause`
- mode_sel  out  4  selects the active generator instance and output mux
- locked  out  1  generator running in mode_sel and frame-aligned
- busy  out  1  state not in {IDLE, RUN}
- err_timeout  out  1  sticky: LOCK timed out
- err_mode  out  1  one-cycle pulse: out-of-range cfg_mode rejected

Behaviour:
- Clock is pclk. Reset rst_n is asynchronous, active-low. All state is on posedge pclk.
- Reset values:
  - state=IDLE, mode_sel=DEFAULT_MODE, pending=DEFAULT_MODE, chg_pend=0.
  - gen_enable=0, gen_pause=0, locked=0, busy=0, err_timeout=0, err_mode=0.
  - cfg_ready reflects IDLE (1).
- Config handshake:
  - cfg_ready=1 only in IDLE or RUN with chg_pend=0.
  - Accept on cfg_valid&&cfg_ready.
  - If cfg_mode<NUM_MODES: pending<=cfg_mode, chg_pend<=1, err_timeout<=0.
  - Otherwise: err_mode=1 for one cycle and nothing else changes.
  - In IDLE, an accept only updates pending; it does not start video.
- Frame start (fs):
  - vs_act = gen_vsync ^ NEG_MASK[mode_sel]; vs_prev is a 1-cycle register of vs_act.
  - Progressive: fs = vs_act & ~vs_prev.
  - Interlaced (ILACE_MASK[mode_sel]): fs = vs_act & ~vs_prev & ~gen_field, i.e. odd field only.
  - fs is qualified only in LOCK, RUN and DRAIN. vs_prev updates in every state.
- FSM:
  - IDLE: gen_enable=0. If run_req, go to SETTLE.
  - SETTLE:
    - On entry: mode_sel<=pending, chg_pend<=0, counter cleared.
    - gen_enable=0. After SETTLE_CYC cycles, go to LOCK.
  - LOCK:
    - gen_enable=1, timeout counter increments.
    - fs: go to RUN, locked<=1.
    - Counter reaches TMO_CYC-1: err_timeout<=1, go to IDLE.
    - If run_req drops: go to IDLE immediately.
  - RUN:
    - gen_enable=1, locked=1.
    - chg_pend or !run_req: go to DRAIN.
  - DRAIN:
    - gen_enable=1; the current frame completes.
    - On fs: gen_enable<=0 and locked<=0 in the same cycle.
    - Then go to SETTLE if run_req, else to IDLE.
    - fs in the same cycle as a run_req change: the sampled run_req decides.
- Pause (RUN only):
  - Assert gen_pause the cycle after pause_req=1 is sampled with gen_de=0, so a pause never splits an active line.
  - Deassert the cycle after pause_req=0.
  - gen_pause is forced to 0 outside RUN.
  - While gen_pause=1, DRAIN entry is deferred: the generator cannot reach fs while frozen.
- A change request in RUN goes via DRAIN to SETTLE with the new mode. A second request is blocked (cfg_ready=0) until the next IDLE or RUN.
- Reset asserted mid-operation returns all outputs to reset values asynchronously. gen_enable drops immediately.

Decomposition:
- Shared package `video_timing_pkg`:
  - mode index localparams (MODE_1080P60=0 … MODE_768P60=11) and NUM_MODES;
  - NEG_MASK and ILACE_MASK constants;
  - FSM state enum (IDLE, SETTLE, LOCK, RUN, DRAIN).
- One sub-module `vts_frame_detect`: polarity normalisation, vs_prev register and field-qualified fs.

Test Plan:
- Reset, then run_req=1 with default mode and a 1080P@60 generator → gen_enable rises 64 cycles after SETTLE entry; locked=1 one cycle after the first vsync rise; mode_sel=0.
- In RUN, cfg_mode=3 (480I@60) → cfg_ready drops; gen_enable stays 1 until the next vsync rise, then 0 for 64 cycles; mode_sel=3; locked re-asserts only on an odd-field vsync falling edge (negated polarity).
- cfg_mode=13 → err_mode pulses for one cycle; pending and mode_sel are unchanged.
- TMO_CYC=1000 with gen_vsync tied low → err_timeout=1 at LOCK cycle 1000; state=IDLE; gen_enable=0; the next valid cfg accept clears err_timeout.
- pause_req=1 during gen_de=1 → gen_pause stays 0 until the first gen_de=0 cycle, then 1; pause_req=0 → gen_pause=0 one cycle later.
- rst_n pulsed low during DRAIN → gen_enable and locked go to 0 asynchronously; mode_sel=DEFAULT_MODE.
